// File: rtl/pipe_elastic_buffer.sv
// pipe_elastic_buffer
//   N-entry elastic buffer between valid/ready pipeline stages. It absorbs up
//   to DEPTH beats of back-pressure, reports its occupancy and an almost-full
//   flag, and supports a synchronous flush. o_ready and o_valid come from
//   registered state only, so neither has a combinational path from the
//   handshake inputs.
//
// Parameters
//   DWIDTH        data width in bits
//   DEPTH         number of entries (>= 2, any value, not only powers of two)
//   AFULL_THRESH  o_almost_full asserts when occupancy >= this (1..DEPTH)
//
// Ports
//   clk            clock, all logic on the rising edge
//   rst            synchronous active-high reset; drops all entries
//   i_flush        synchronous flush; drops all entries, overrides push/pop
//   i_data/i_valid upstream beat
//   o_ready        buffer can accept a beat this cycle
//   o_data/o_valid head-of-buffer beat (o_data is don't-care when !o_valid)
//   i_ready        downstream ready
//   o_count        current occupancy
//   o_almost_full  o_count >= AFULL_THRESH
module pipe_elastic_buffer #(
    parameter int DWIDTH       = 8,
    parameter int DEPTH        = 4,
    parameter int AFULL_THRESH = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic [DWIDTH-1:0]          i_data,
    input  logic                       i_valid,
    output logic                       o_ready,
    output logic [DWIDTH-1:0]          o_data,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_almost_full
);

    localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AFULL_THRESH);

    typedef enum logic [1:0] {
        EMPTY,
        PART,
        FULL
    } state_t;

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    state_t            state;

    logic push;
    logic pop;

    // Explicit wrap so non-power-of-two depths index only valid entries.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign push = i_valid & o_ready;
    assign pop  = o_valid & i_i_ready_alias();

    // Wrapper kept trivial; see pop above.
    function automatic logic i_i_ready_alias();
        return i_ready;
    endfunction

    // The enum state is kept in lock-step with count so the handshake flags
    // decode from a 2-bit register instead of a full-width count compare.
    assign o_ready       = (state != FULL);
    assign o_valid       = (state != EMPTY);
    assign o_data        = mem[rd_ptr];
    assign o_count       = count;
    assign o_almost_full = (count >= AF_CNT);

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            state  <= EMPTY;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10: begin
                    count <= count + 1'b1;
                    state <= (count == FULL_CNT - 1'b1) ? FULL : PART;
                end
                2'b01: begin
                    count <= count - 1'b1;
                    state <= (count == {{(CW-1){1'b0}}, 1'b1}) ? EMPTY : PART;
                end
                default: begin
                    // idle or simultaneous push/pop: occupancy unchanged
                end
            endcase
        end
    end

    // Data storage is not reset; a write racing a flush/reset is harmless
    // because wr_ptr returns to 0 and the entry is never read as valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= i_data;
    end

endmodule
